// File: rtl/filter_stream_source.sv
// Transmit side of the filter input stream: reads coefficients and one pixel frame
// from two synchronous-read memories and emits them as a bubble-free valid/id/data stream.
module filter_stream_source #(
   parameter int unsigned DATA_BIT     = 15,
   parameter int unsigned DATA_IDBIT   = 2,
   parameter int unsigned ROW_WIDTH    = 512,
   parameter int unsigned COL_WIDTH    = 512,
   parameter int unsigned MASK_WIDTH   = 7,
   parameter int unsigned CF_ADDR_BIT  = 6,
   parameter int unsigned PIX_ADDR_BIT = 18,
   parameter int unsigned GAP_CYCLES   = 2,
   parameter int unsigned FLUSH_CYCLES = 2048
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    load_cf,
   output logic [CF_ADDR_BIT-1:0]  cf_rd_addr,
   input  logic [DATA_BIT-1:0]     cf_rd_data,
   output logic [PIX_ADDR_BIT-1:0] pix_rd_addr,
   input  logic [DATA_BIT-1:0]     pix_rd_data,
   output logic                    tx_valid,
   output logic [DATA_IDBIT-1:0]   tx_id,
   output logic [DATA_BIT-1:0]     tx_data,
   output logic                    busy,
   output logic                    done
);

   localparam int unsigned CF_COUNT = MASK_WIDTH * MASK_WIDTH;
   localparam int unsigned X_BIT    = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;
   localparam int unsigned Y_BIT    = (COL_WIDTH > 1) ? $clog2(COL_WIDTH) : 1;
   localparam int unsigned WAIT_BIT = $clog2(FLUSH_CYCLES + GAP_CYCLES + 3);

   typedef enum logic [2:0] {
      IDLE, CF_RD, GAP, PIX_RD, DRAIN, FLUSH, DONE_S
   } state_t;

   state_t              state;
   logic [X_BIT-1:0]    x_cnt;
   logic [Y_BIT-1:0]    y_cnt;
   logic [WAIT_BIT-1:0] wait_cnt;
   logic                rd_valid;   // address on the memory port this cycle
   logic                rd_id;      // 1 = coefficient read
   logic                mem_valid;  // read data on the memory output this cycle
   logic                mem_id;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         x_cnt       <= '0;
         y_cnt       <= '0;
         wait_cnt    <= '0;
         rd_valid    <= 1'b0;
         rd_id       <= 1'b0;
         mem_valid   <= 1'b0;
         mem_id      <= 1'b0;
         cf_rd_addr  <= '0;
         pix_rd_addr <= '0;
         tx_valid    <= 1'b0;
         tx_id       <= '0;
         tx_data     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         done      <= 1'b0;
         rd_valid  <= 1'b0;
         mem_valid <= rd_valid;
         mem_id    <= rd_id;
         tx_valid  <= mem_valid;
         // Output register: data holds when idle, id falls back to pixel id 0
         if (mem_valid) begin
            tx_id   <= DATA_IDBIT'(mem_id);
            tx_data <= mem_id ? cf_rd_data : pix_rd_data;
         end else begin
            tx_id <= '0;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  busy     <= 1'b1;
                  rd_valid <= 1'b1;
                  if (load_cf) begin
                     state      <= CF_RD;
                     cf_rd_addr <= '0;
                     rd_id      <= 1'b1;
                  end else begin
                     state       <= PIX_RD;
                     pix_rd_addr <= '0;
                     x_cnt       <= '0;
                     y_cnt       <= '0;
                     rd_id       <= 1'b0;
                  end
               end
            end
            CF_RD: begin
               if (cf_rd_addr == CF_ADDR_BIT'(CF_COUNT - 1)) begin
                  state    <= GAP;
                  wait_cnt <= '0;
               end else begin
                  cf_rd_addr <= cf_rd_addr + CF_ADDR_BIT'(1);
                  rd_valid   <= 1'b1;
               end
            end
            GAP: begin
               if (wait_cnt == WAIT_BIT'(GAP_CYCLES - 1)) begin
                  state       <= PIX_RD;
                  pix_rd_addr <= '0;
                  x_cnt       <= '0;
                  y_cnt       <= '0;
                  rd_valid    <= 1'b1;
                  rd_id       <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_BIT'(1);
               end
            end
            PIX_RD: begin
               // Row wrap keeps issuing every cycle so the stream has no bubbles
               if (x_cnt == X_BIT'(ROW_WIDTH - 1) && y_cnt == Y_BIT'(COL_WIDTH - 1)) begin
                  state    <= DRAIN;
                  wait_cnt <= '0;
               end else begin
                  rd_valid    <= 1'b1;
                  pix_rd_addr <= pix_rd_addr + PIX_ADDR_BIT'(1);
                  if (x_cnt == X_BIT'(ROW_WIDTH - 1)) begin
                     x_cnt <= '0;
                     y_cnt <= y_cnt + Y_BIT'(1);
                  end else begin
                     x_cnt <= x_cnt + X_BIT'(1);
                  end
               end
            end
            DRAIN: begin
               if (wait_cnt == WAIT_BIT'(1)) begin
                  state    <= FLUSH;
                  wait_cnt <= '0;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_BIT'(1);
               end
            end
            FLUSH: begin
               if (wait_cnt == WAIT_BIT'(FLUSH_CYCLES - 1)) begin
                  state <= DONE_S;
                  done  <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_BIT'(1);
               end
            end
            DONE_S: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_filter_stream_source.sv
// Randomized self-checking bench for filter_stream_source: every cycle of every frame
// is compared against a timeline computed from the stream's timing rules.
module tb_filter_stream_source;

   localparam int unsigned DATA_BIT     = 15;
   localparam int unsigned DATA_IDBIT   = 2;
   localparam int unsigned ROW_WIDTH    = 8;
   localparam int unsigned COL_WIDTH    = 4;
   localparam int unsigned MASK_WIDTH   = 3;
   localparam int unsigned CF_ADDR_BIT  = 6;
   localparam int unsigned PIX_ADDR_BIT = 18;
   localparam int unsigned GAP_CYCLES   = 2;
   localparam int unsigned FLUSH_CYCLES = 5;
   localparam int M2 = MASK_WIDTH * MASK_WIDTH;
   localparam int NP = ROW_WIDTH * COL_WIDTH;

   logic                    clk;
   logic                    reset;
   logic                    start;
   logic                    load_cf;
   logic [CF_ADDR_BIT-1:0]  cf_rd_addr;
   logic [DATA_BIT-1:0]     cf_rd_data;
   logic [PIX_ADDR_BIT-1:0] pix_rd_addr;
   logic [DATA_BIT-1:0]     pix_rd_data;
   logic                    tx_valid;
   logic [DATA_IDBIT-1:0]   tx_id;
   logic [DATA_BIT-1:0]     tx_data;
   logic                    busy;
   logic                    done;

   int vectors;
   int miscompares;
   int last_data;
   int last_cf;
   int last_pix;

   filter_stream_source #(
      .DATA_BIT(DATA_BIT), .DATA_IDBIT(DATA_IDBIT), .ROW_WIDTH(ROW_WIDTH),
      .COL_WIDTH(COL_WIDTH), .MASK_WIDTH(MASK_WIDTH), .CF_ADDR_BIT(CF_ADDR_BIT),
      .PIX_ADDR_BIT(PIX_ADDR_BIT), .GAP_CYCLES(GAP_CYCLES), .FLUSH_CYCLES(FLUSH_CYCLES)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .load_cf(load_cf),
      .cf_rd_addr(cf_rd_addr), .cf_rd_data(cf_rd_data),
      .pix_rd_addr(pix_rd_addr), .pix_rd_data(pix_rd_data),
      .tx_valid(tx_valid), .tx_id(tx_id), .tx_data(tx_data),
      .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read memories: data = address + offset, one cycle after address
   always @(posedge clk) begin
      cf_rd_data  <= DATA_BIT'(int'(cf_rd_addr) + 100);
      pix_rd_data <= DATA_BIT'(int'(pix_rd_addr) + 500);
   end

   task automatic check(input string tag, input int got, input int exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, ".tx_valid"}, int'(tx_valid), 0);
      check({tag, ".tx_id"}, int'(tx_id), 0);
      check({tag, ".tx_data"}, int'(tx_data), last_data);
      check({tag, ".busy"}, int'(busy), 0);
      check({tag, ".done"}, int'(done), 0);
   endtask

   // Called in cycle 0 (drive slot); returns in the last checked cycle.
   // abort_at > 0 pulses reset in that frame-relative cycle.
   task automatic run_frame(input bit load, input int abort_at);
      int p0, lastb, tdone, tend, pix_beats, cf_beats;
      bit ev;
      int eid, edata;
      p0        = load ? 3 + M2 + GAP_CYCLES : 3;
      lastb     = p0 + NP - 1;
      tdone     = lastb + FLUSH_CYCLES + 1;
      tend      = (abort_at > 0) ? abort_at : tdone;
      pix_beats = 0;
      cf_beats  = 0;
      start     = 1'b1;
      load_cf   = load;
      for (int t = 1; t <= tend; t++) begin
         @(posedge clk); #1;
         if (t == abort_at) begin
            reset = 1'b1;
            start = 1'b0;
         end else begin
            start   = 1'($urandom_range(0, 1));
            load_cf = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         ev = 1'b0; eid = 0; edata = 0;
         if (load && t >= 3 && t < 3 + M2) begin
            ev = 1'b1; eid = 1; edata = 100 + (t - 3);
         end else if (t >= p0 && t <= lastb) begin
            ev = 1'b1; eid = 0; edata = 500 + (t - p0);
         end
         if (ev) last_data = edata;
         if (load && t >= 1 && t <= M2) last_cf = t - 1;
         if (t >= p0 - 2 && t <= lastb - 2) last_pix = t - (p0 - 2);
         check("tx_valid", int'(tx_valid), int'(ev));
         check("tx_id", int'(tx_id), eid);
         check("tx_data", int'(tx_data), last_data);
         check("busy", int'(busy), 1);
         check("done", int'(done), (t == tdone) ? 1 : 0);
         check("cf_rd_addr", int'(cf_rd_addr), last_cf);
         check("pix_rd_addr", int'(pix_rd_addr), last_pix);
         if (tx_valid && tx_id == 0) pix_beats++;
         if (tx_valid && tx_id == 1) cf_beats++;
      end
      if (abort_at > 0) begin
         @(posedge clk); #1;
         reset = 1'b0;
         @(negedge clk);
         last_data = 0; last_cf = 0; last_pix = 0;
         check_quiet("abort");
         check("abort.cf_rd_addr", int'(cf_rd_addr), 0);
         check("abort.pix_rd_addr", int'(pix_rd_addr), 0);
      end else begin
         check("pix_beat_count", pix_beats, NP);
         check("cf_beat_count", cf_beats, load ? M2 : 0);
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         start   = 1'b0;
         load_cf = 1'($urandom_range(0, 1));
         @(negedge clk);
         check_quiet("idle");
      end
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      last_data = 0; last_cf = 0; last_pix = 0;
      reset = 1'b1; start = 1'b0; load_cf = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_quiet("reset");
      check("reset.cf_rd_addr", int'(cf_rd_addr), 0);
      check("reset.pix_rd_addr", int'(pix_rd_addr), 0);

      next_cycle(); run_frame(1'b1, 0);     // coefficients + frame
      idle_cycles(2);
      next_cycle(); run_frame(1'b0, 0);     // pixels only
      idle_cycles(1);
      next_cycle(); run_frame(1'b1, 20);    // reset mid-transfer
      next_cycle(); run_frame(1'b0, 0);     // restart from address 0
      next_cycle(); run_frame(1'b1, 0);     // back-to-back after done
      next_cycle(); run_frame(1'b1, 0);

      for (int f = 0; f < 8; f++) begin
         bit ld;
         int ab;
         ld = 1'($urandom_range(0, 1));
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0;
         idle_cycles(int'($urandom_range(0, 3)));
         next_cycle();
         run_frame(ld, ab);
      end
      idle_cycles(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
